// File: rtl/modulo_oposto_serial_pkg.sv
`timescale 1ns/1ps
// Shared arithmetic definitions for the serial negation datapath.
// Holds the FSM encoding, default operand width and counter sizing.
package modulo_oposto_serial_pkg;

  localparam int LARGURA_PADRAO = 8;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CALCULA = 2'd1,
    CONCLUI = 2'd2
  } estado_t;

  function automatic int largura_contador(input int largura);
    return $clog2(largura + 1);
  endfunction

  localparam int CNT_W = largura_contador(LARGURA_PADRAO);

endpackage

// File: rtl/modulo_oposto_serial_if.sv
`timescale 1ns/1ps
// Operand/result bus of the serial negation unit: start/entrada in, status and result out.
// The bus has no backpressure; start is only taken while pronto is high.
interface modulo_oposto_serial_if
  import modulo_oposto_serial_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
);
  logic               start;
  logic [LARGURA:0]   entrada;
  logic               pronto;
  logic               ocupado;
  logic               valido;
  logic [LARGURA-1:0] saida;
  logic               erro;

  modport master (
    output start, entrada,
    input  pronto, ocupado, valido, saida, erro
  );

  modport slave (
    input  start, entrada,
    output pronto, ocupado, valido, saida, erro
  );
endinterface

// File: rtl/modulo_oposto_serial_negador.sv
`timescale 1ns/1ps
// Bit-serial two's-complement negation, LSB first: copy bits up to and including the first 1, invert the rest.
// Zero latency on bit_out; the seen-one flag updates on each enabled cycle; no backpressure.
module negador_bit_serial (
  input  logic clk,
  input  logic rst_n,
  input  logic limpa,
  input  logic habilita,
  input  logic bit_in,
  output logic bit_out
);

  logic visto_um;

  assign bit_out = visto_um ? ~bit_in : bit_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      visto_um <= 1'b0;
    end else if (limpa) begin
      visto_um <= 1'b0;
    end else if (habilita) begin
      visto_um <= visto_um | bit_in;
    end
  end

endmodule

// File: rtl/modulo_oposto_serial.sv
`timescale 1ns/1ps
// Serial negation of a (LARGURA+1)-bit signed operand into a LARGURA-bit magnitude plus overflow flag.
// valido in the 10th cycle after accept (LARGURA=8), one op per LARGURA+3 cycles; start ignored unless pronto.
module modulo_oposto_serial
  import modulo_oposto_serial_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input logic                 clk,
  input logic                 rst_n,
  modulo_oposto_serial_if.slave bus
);

  localparam int CW = largura_contador(LARGURA);

  estado_t            estado, estado_prox;
  logic [LARGURA:0]   operando;
  logic [LARGURA:0]   resultado;
  logic [LARGURA:0]   resultado_prox;
  logic [CW-1:0]      contador;
  logic [LARGURA-1:0] saida_q;
  logic               erro_q;
  logic               aceita;
  logic               desloca;
  logic               ultimo;
  logic               bit_neg;

  assign aceita  = (estado == OCIOSO) && bus.start;
  assign desloca = (estado == CALCULA);
  assign ultimo  = desloca && (contador == CW'(LARGURA));

  // Negated bits enter from the MSB side so the LSB lands at bit 0 after LARGURA+1 shifts.
  assign resultado_prox = {bit_neg, resultado[LARGURA:1]};

  negador_bit_serial u_negador (
    .clk      (clk),
    .rst_n    (rst_n),
    .limpa    (aceita),
    .habilita (desloca),
    .bit_in   (operando[0]),
    .bit_out  (bit_neg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= OCIOSO;
    end else begin
      estado <= estado_prox;
    end
  end

  always_comb begin
    estado_prox = estado;
    unique case (estado)
      OCIOSO:  if (bus.start) estado_prox = CALCULA;
      CALCULA: if (ultimo)    estado_prox = CONCLUI;
      CONCLUI:                estado_prox = OCIOSO;
      default:                estado_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operando  <= '0;
      resultado <= '0;
      contador  <= '0;
    end else if (aceita) begin
      operando  <= bus.entrada;
      resultado <= '0;
      contador  <= '0;
    end else if (desloca) begin
      operando  <= operando >> 1;
      resultado <= resultado_prox;
      contador  <= contador + CW'(1);
    end
  end

  // The final bit is folded in on the way into the output register, so saida is fresh exactly in CONCLUI.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      saida_q <= '0;
      erro_q  <= 1'b0;
    end else if (ultimo) begin
      saida_q <= resultado_prox[LARGURA-1:0];
      erro_q  <= resultado_prox[LARGURA];
    end
  end

  assign bus.pronto  = (estado == OCIOSO);
  assign bus.ocupado = (estado == CALCULA);
  assign bus.valido  = (estado == CONCLUI);
  assign bus.saida   = saida_q;
  assign bus.erro    = erro_q;

endmodule

// File: tb/tb_modulo_oposto_serial.sv
`timescale 1ns/1ps
// Randomised and directed bench for modulo_oposto_serial against an arithmetic reference model.
module tb_modulo_oposto_serial;
  import modulo_oposto_serial_pkg::*;

  localparam int L = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  modulo_oposto_serial_if #(.LARGURA(L)) bus ();

  modulo_oposto_serial #(.LARGURA(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: negate the signed operand as an integer, then judge range.
  function automatic void referencia(input logic [L:0] e, output logic [L-1:0] s, output logic er);
    int v;
    int neg;
    v   = e[L] ? int'(e) - (1 << (L + 1)) : int'(e);
    neg = -v;
    er  = (neg < 0) || (neg > (1 << L) - 1);
    s   = neg[L-1:0];
  endfunction

  // Abstract timing model: busy for L+2 cycles after an accept, result shown on the last of them.
  bit           m_busy    = 1'b0;
  int           m_k       = 0;
  logic [L:0]   m_op      = '0;
  logic [L-1:0] m_saida   = '0;
  logic         m_erro    = 1'b0;
  int           n_accepts = 0;
  logic         prev_valido = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_k     = 0;
      m_saida = '0;
      m_erro  = 1'b0;
    end else if (!m_busy) begin
      if (bus.start) begin
        m_op   = bus.entrada;
        m_busy = 1'b1;
        m_k    = 0;
        n_accepts++;
      end
    end else begin
      m_k++;
      if (m_k == L + 1) referencia(m_op, m_saida, m_erro);
      if (m_k == L + 2) m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("pronto",  bus.pronto,  !m_busy);
      chk("ocupado", bus.ocupado, m_busy && (m_k <= L));
      chk("valido",  bus.valido,  m_busy && (m_k == L + 1));
      chk("saida",   bus.saida,   m_saida);
      chk("erro",    bus.erro,    m_erro);
      chk("onehot",  32'(bus.pronto) + 32'(bus.ocupado) + 32'(bus.valido), 1);
      chk("valido_twice", prev_valido & bus.valido, 1'b0);
      prev_valido = bus.valido;
    end else begin
      prev_valido = 1'b0;
    end
  end

  // Called at a negedge; returns at the negedge where valido is seen.
  task automatic run_op(input logic [L:0] v, input logic [L-1:0] es, input logic ee,
                        input logic chk_hold, input logic [L-1:0] hold_val, output int lat);
    int n;
    n = 0;
    while (!bus.pronto && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wait_pronto", bus.pronto, 1'b1);
    bus.start   = 1'b1;
    bus.entrada = v;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.entrada = (L+1)'($urandom);
    lat = 1;
    while (!bus.valido && lat < 40) begin
      if (chk_hold && lat == 5) chk("hold_saida", bus.saida, hold_val);
      @(negedge clk);
      lat++;
    end
    chk("valido_seen", bus.valido, 1'b1);
    chk("dut_saida",   bus.saida, es);
    chk("dut_erro",    bus.erro,  ee);
    chk("model_saida", m_saida,   es);
    chk("model_erro",  m_erro,    ee);
  endtask

  logic [L:0]   bv [6] = '{9'h000, 9'h1FF, 9'h180, 9'h101, 9'h100, 9'h001};
  logic [L-1:0] bs [6] = '{8'h00,  8'h01,  8'h80,  8'hFF,  8'h00,  8'hFF};
  logic         be [6] = '{1'b0,   1'b0,   1'b0,   1'b0,   1'b1,   1'b1};

  initial begin
    int lat;
    int pulses;
    int acc0;
    logic [L:0]   v;
    logic [L-1:0] es;
    logic         ee;

    bus.start   = 1'b0;
    bus.entrada = '0;
    #7;
    chk("rst_pronto",  bus.pronto,  1'b1);
    chk("rst_ocupado", bus.ocupado, 1'b0);
    chk("rst_valido",  bus.valido,  1'b0);
    chk("rst_saida",   bus.saida,   8'h00);
    chk("rst_erro",    bus.erro,    1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // -10 with latency check
    run_op(9'h1F6, 8'd10, 1'b0, 1'b0, '0, lat);
    chk("latency", lat, 10);
    @(negedge clk);
    chk("pronto_after", bus.pronto, 1'b1);

    for (int i = 0; i < 6; i++) begin
      run_op(bv[i], bs[i], be[i], 1'b0, '0, lat);
    end

    // start held high with a changing operand every cycle
    @(negedge clk);
    acc0      = n_accepts;
    pulses    = 0;
    bus.start = 1'b1;
    for (int i = 0; i < 110; i++) begin
      bus.entrada = (L+1)'($urandom);
      @(negedge clk);
      if (bus.valido) pulses++;
    end
    bus.start = 1'b0;
    chk("held_pulses",  pulses, 10);
    chk("held_accepts", n_accepts - acc0, 10);

    // asynchronous reset in the middle of CALCULA
    @(negedge clk);
    while (!bus.pronto) @(negedge clk);
    bus.start   = 1'b1;
    bus.entrada = 9'h1B3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_pronto",  bus.pronto,  1'b1);
    chk("arst_ocupado", bus.ocupado, 1'b0);
    chk("arst_valido",  bus.valido,  1'b0);
    chk("arst_saida",   bus.saida,   8'h00);
    chk("arst_erro",    bus.erro,    1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    run_op(9'h1DB, 8'd37, 1'b0, 1'b0, '0, lat);

    // back-to-back: -5 then -200, saida holds 5 during the second op
    @(negedge clk);
    run_op(9'h1FB, 8'd5, 1'b0, 1'b0, '0, lat);
    @(negedge clk);
    run_op(9'h138, 8'd200, 1'b0, 1'b1, 8'd5, lat);

    // random operands with random idle gaps
    for (int i = 0; i < 25; i++) begin
      v = (L+1)'($urandom_range(0, (1 << (L + 1)) - 1));
      referencia(v, es, ee);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(v, es, ee, 1'b0, '0, lat);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
